// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings {cs_n,ras_n,cas_n,we_n} and arbiter state type.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    S_INIT,
    S_ARB,
    S_AREF,
    S_WRITE,
    S_READ
  } state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh request generator: raises ref_pending every REF_CYCLES clocks
// after init_done and flags a sticky overrun if a request is still unserved at the next wrap.
module sdram_ref_timer #(
  parameter int REF_CYCLES = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic init_done,
  input  logic ref_ack,
  output logic ref_pending,
  output logic ref_overrun
);

  localparam int CW = (REF_CYCLES > 2) ? $clog2(REF_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REF_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          wrap;

  always_comb begin
    count_d   = count_q;
    wrap      = 1'b0;
    if (init_done) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
    // a wrap on the same edge as the grant re-arms the request
    pending_d = pending_q;
    if (wrap) begin
      pending_d = 1'b1;
    end else if (ref_ack) begin
      pending_d = 1'b0;
    end
    overrun_d = overrun_q | (wrap & pending_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign ref_pending = pending_q;
  assign ref_overrun = overrun_q;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM pin arbiter. States: S_INIT init owns pins | S_ARB pick next owner (NOP) |
// S_AREF refresh owns pins | S_WRITE write owns pins | S_READ read owns pins.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REF_CYCLES = 780,
  parameter int ADDR_W     = 13,
  parameter int BANK_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  output logic              ref_en,
  input  logic              ref_end,
  input  logic [3:0]        ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic              wr_req,
  output logic              wr_en,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  output logic              rd_en,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              ref_pending,
  output logic              ref_overrun,
  output logic [3:0]        sdram_cmd,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr
);

  state_e            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic              ref_en_q, ref_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ref_ack;

  sdram_ref_timer #(.REF_CYCLES(REF_CYCLES)) u_ref_timer (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
    .ref_ack     (ref_ack),
    .ref_pending (ref_pending),
    .ref_overrun (ref_overrun)
  );

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    case (state_q)
      S_INIT:  if (init_done) state_d = S_ARB;
      S_ARB: begin
        if (ref_pending)           state_d = S_AREF;
        else if (wr_req && rd_req) state_d = last_wr_q ? S_READ : S_WRITE;
        else if (wr_req)           state_d = S_WRITE;
        else if (rd_req)           state_d = S_READ;
      end
      S_AREF:  if (ref_end) state_d = S_ARB;
      S_WRITE: if (wr_end)  state_d = S_ARB;
      S_READ:  if (rd_end)  state_d = S_ARB;
      default: state_d = S_INIT;
    endcase
    if (state_q == S_ARB && state_d == S_WRITE) last_wr_d = 1'b1;
    if (state_q == S_ARB && state_d == S_READ)  last_wr_d = 1'b0;
    ref_en_d = (state_d == S_AREF);
    wr_en_d  = (state_d == S_WRITE);
    rd_en_d  = (state_d == S_READ);
  end

  assign ref_ack = (state_q == S_ARB) && (state_d == S_AREF);

  // refresh has no bank input, so its bank stays at zero like NOP
  always_comb begin
    cmd_d  = CMD_NOP;
    bank_d = '0;
    addr_d = '0;
    case (state_q)
      S_INIT:  begin cmd_d = init_cmd; bank_d = init_bank; addr_d = init_addr; end
      S_AREF:  begin cmd_d = ref_cmd;  addr_d = ref_addr; end
      S_WRITE: begin cmd_d = wr_cmd;   bank_d = wr_bank;   addr_d = wr_addr; end
      S_READ:  begin cmd_d = rd_cmd;   bank_d = rd_bank;   addr_d = rd_addr; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      last_wr_q <= 1'b0;
      ref_en_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cmd_q     <= CMD_NOP;
      bank_q    <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      ref_en_q  <= ref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      cmd_q     <= cmd_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
    end
  end

  assign ref_en     = ref_en_q;
  assign wr_en      = wr_en_q;
  assign rd_en      = rd_en_q;
  assign sdram_cmd  = cmd_q;
  assign sdram_bank = bank_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and random checks of sdram_arbiter against a bus-ownership reference model.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int REF = 780;
  localparam int AW  = 13;
  localparam int BW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic [3:0]    init_cmd = 4'b0010;
  logic [BW-1:0] init_bank = '0;
  logic [AW-1:0] init_addr = '0;
  logic          ref_en, ref_end = 1'b0;
  logic [3:0]    ref_cmd = CMD_AREF;
  logic [AW-1:0] ref_addr = '0;
  logic          wr_req = 1'b0, wr_en, wr_end = 1'b0;
  logic [3:0]    wr_cmd = CMD_WR;
  logic [BW-1:0] wr_bank = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          rd_req = 1'b0, rd_en, rd_end = 1'b0;
  logic [3:0]    rd_cmd = CMD_RD;
  logic [BW-1:0] rd_bank = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          ref_pending, ref_overrun;
  logic [3:0]    sdram_cmd;
  logic [BW-1:0] sdram_bank;
  logic [AW-1:0] sdram_addr;

  always #5 clk = ~clk;

  sdram_arbiter #(.REF_CYCLES(REF), .ADDR_W(AW), .BANK_W(BW)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .ref_en(ref_en), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd),
    .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd),
    .rd_bank(rd_bank), .rd_addr(rd_addr),
    .ref_pending(ref_pending), .ref_overrun(ref_overrun),
    .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus, refresh requests outstanding, clocks since init.
  localparam int OWN_INIT = 0, OWN_IDLE = 1, OWN_REF = 2, OWN_WR = 3, OWN_RD = 4;
  int            owner = OWN_INIT;
  int            ticks = 0;
  int            pend = 0;
  int            ovr = 0;
  int            last_wr = 0;
  logic [3:0]    m_cmd = 4'b0111;
  logic [BW-1:0] m_bank = '0;
  logic [AW-1:0] m_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int nxt;
    bit wrap;
    bit served;
    if (rst) begin
      owner = OWN_INIT; ticks = 0; pend = 0; ovr = 0; last_wr = 0;
      m_cmd = 4'b0111; m_bank = '0; m_addr = '0;
      return;
    end
    m_cmd = 4'b0111; m_bank = '0; m_addr = '0;
    case (owner)
      OWN_INIT: begin m_cmd = init_cmd; m_bank = init_bank; m_addr = init_addr; end
      OWN_REF:  begin m_cmd = ref_cmd;  m_addr = ref_addr; end
      OWN_WR:   begin m_cmd = wr_cmd;   m_bank = wr_bank; m_addr = wr_addr; end
      OWN_RD:   begin m_cmd = rd_cmd;   m_bank = rd_bank; m_addr = rd_addr; end
      default: ;
    endcase
    wrap = 1'b0;
    if (init_done) begin
      ticks++;
      wrap = ((ticks % REF) == 0);
    end
    nxt = owner;
    if (owner == OWN_INIT && init_done) nxt = OWN_IDLE;
    else if (owner == OWN_IDLE) begin
      if (pend != 0)            nxt = OWN_REF;
      else if (wr_req && rd_req) nxt = (last_wr != 0) ? OWN_RD : OWN_WR;
      else if (wr_req)           nxt = OWN_WR;
      else if (rd_req)           nxt = OWN_RD;
    end
    else if (owner == OWN_REF && ref_end) nxt = OWN_IDLE;
    else if (owner == OWN_WR && wr_end)   nxt = OWN_IDLE;
    else if (owner == OWN_RD && rd_end)   nxt = OWN_IDLE;
    served = (owner == OWN_IDLE && nxt == OWN_REF);
    if (wrap && pend != 0) ovr = 1;
    if (wrap) pend = 1;
    else if (served) pend = 0;
    if (nxt == OWN_WR && owner == OWN_IDLE) last_wr = 1;
    if (nxt == OWN_RD && owner == OWN_IDLE) last_wr = 0;
    owner = nxt;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("model",
        {8'h0, ref_en, wr_en, rd_en, ref_pending, ref_overrun, sdram_cmd, sdram_bank, sdram_addr},
        {8'h0, owner == OWN_REF, owner == OWN_WR, owner == OWN_RD, pend[0], ovr[0],
         m_cmd, m_bank, m_addr});
    init_bank = BW'($urandom); init_addr = AW'($urandom);
    ref_cmd = 4'($urandom);    ref_addr = AW'($urandom);
    wr_cmd = 4'($urandom); wr_bank = BW'($urandom); wr_addr = AW'($urandom);
    rd_cmd = 4'($urandom); rd_bank = BW'($urandom); rd_addr = AW'($urandom);
  endtask

  task automatic pulse_ref_end();
    ref_end = 1'b1; cycle(); ref_end = 1'b0;
  endtask

  initial begin
    int n;
    // reset and init hold
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rst_cmd", 32'(sdram_cmd), 32'(4'b0111));
    end
    rst = 1'b0;
    cycle();
    chk("init_pins", 32'(sdram_cmd), 32'(4'b0010));
    chk("init_no_grant", 32'({ref_en, wr_en, rd_en}), 32'd0);
    repeat (3) cycle();

    init_cmd = 4'b0111;
    init_done = 1'b1;
    cycle();
    chk("arb_nop", 32'(sdram_cmd), 32'(4'b0111));
    cycle();
    chk("arb_nop2", 32'(sdram_cmd), 32'(4'b0111));

    // refresh period
    while (ticks < REF - 1) cycle();
    chk("pend_early", 32'(ref_pending), 32'd0);
    cycle();
    chk("pend_780", 32'(ref_pending), 32'd1);
    cycle();
    chk("ref_grant", 32'(ref_en), 32'd1);
    repeat (3) cycle();
    pulse_ref_end();
    chk("ref_drop", 32'(ref_en), 32'd0);
    while (ticks < 2 * REF - 1) cycle();
    chk("pend_early2", 32'(ref_pending), 32'd0);
    cycle();
    chk("pend_1560", 32'(ref_pending), 32'd1);
    cycle();
    pulse_ref_end();
    cycle();

    // contested grant alternation
    wr_req = 1'b1; rd_req = 1'b1;
    n = 0;
    while (!(wr_en || rd_en) && n < 10) begin cycle(); n++; end
    chk("contest_first", 32'({wr_en, rd_en}), 32'b10);
    repeat (4) cycle();
    wr_end = 1'b1; cycle(); wr_end = 1'b0;
    chk("wr_drop", 32'({wr_en, rd_en}), 32'd0);
    cycle();
    chk("alt_rd", 32'({wr_en, rd_en}), 32'b01);
    chk("nop_gap", 32'(sdram_cmd), 32'(4'b0111));
    repeat (3) cycle();
    rd_end = 1'b1; cycle(); rd_end = 1'b0;
    cycle();
    chk("alt_wr", 32'({wr_en, rd_en}), 32'b10);

    // refresh arrives during a write burst
    n = 0;
    while (!ref_pending && n < 1000) begin cycle(); n++; end
    chk("pend_in_wr", 32'(ref_pending), 32'd1);
    repeat (5) cycle();
    chk("wr_held", 32'(wr_en), 32'd1);
    wr_end = 1'b1; cycle(); wr_end = 1'b0;
    chk("wr_end_drop", 32'(wr_en), 32'd0);
    cycle();
    chk("ref_before_rd", 32'({ref_en, wr_en, rd_en}), 32'b100);
    repeat (2) cycle();
    pulse_ref_end();
    cycle();
    chk("rd_after_ref", 32'({ref_en, wr_en, rd_en}), 32'b001);

    // overrun: hold the write burst across two wraps
    rd_req = 1'b0;
    rd_end = 1'b1; cycle(); rd_end = 1'b0;
    cycle();
    chk("ovr_wr", 32'(wr_en), 32'd1);
    n = 0;
    while (!ref_pending && n < 1000) begin cycle(); n++; end
    chk("ovr_first_wrap", 32'({ref_pending, ref_overrun}), 32'b10);
    n = 0;
    while (!ref_overrun && n < 1000) begin cycle(); n++; end
    chk("ovr_set", 32'(ref_overrun), 32'd1);
    chk("ovr_at_wrap", 32'(ticks % REF), 32'd0);
    wr_req = 1'b0;
    wr_end = 1'b1; cycle(); wr_end = 1'b0;
    repeat (2) cycle();
    pulse_ref_end();
    repeat (5) cycle();
    chk("ovr_sticky", 32'(ref_overrun), 32'd1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) wr_req = ~wr_req;
      if ($urandom_range(15) == 0) rd_req = ~rd_req;
      ref_end = ref_en ? ($urandom_range(5) == 0) : ($urandom_range(49) == 0);
      wr_end  = wr_en  ? ($urandom_range(ref_pending ? 2 : 7) == 0) : ($urandom_range(49) == 0);
      rd_end  = rd_en  ? ($urandom_range(ref_pending ? 2 : 7) == 0) : ($urandom_range(49) == 0);
      cycle();
    end
    ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;

    // reset in the middle of a read
    wr_req = 1'b0; rd_req = 1'b1;
    n = 0;
    while (!rd_en && n < 3000) begin
      wr_end = wr_en; ref_end = ref_en;
      cycle(); n++;
    end
    wr_end = 1'b0; ref_end = 1'b0;
    chk("rd_granted", 32'(rd_en), 32'd1);
    rd_cmd = CMD_RD;
    rst = 1'b1;
    cycle();
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_mid_cmd", 32'(sdram_cmd), 32'(4'b0111));
    chk("rst_ovr", 32'(ref_overrun), 32'd0);
    rst = 1'b0; rd_req = 1'b0;
    init_cmd = 4'b0010;
    cycle();
    chk("rst_to_init", 32'(sdram_cmd), 32'(4'b0010));
    repeat (5) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sits between the SDRAM sub-controllers (init, auto-refresh, burst write, burst read) and the SDRAM command/address pins inside sdram_top.
- Holds the pins in the init sequencer's control until init_done.
- Then generates periodic refresh requests and grants the shared SDRAM bus to one requester at a time: refresh has priority, and write/read alternate fairly.
- The selected requester's command, bank and address are registered onto the pins.

Parameters:
- REF_CYCLES, 780: clk cycles between refresh requests (7.8 us at 100 MHz; 64 ms / 8192 rows).
- ADDR_W, 13: SDRAM address width.
- BANK_W, 2: SDRAM bank width.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- init_done  in  1  init sequencer finished (level, stays high).
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init sequencer.
- init_bank  in  BANK_W  init bank.
- init_addr  in  ADDR_W  init address.
- ref_en  out  1  grant to refresh sub-controller.
- ref_end  in  1  refresh sequence complete (1-cycle pulse).
- ref_cmd  in  4  refresh command.
- ref_addr  in  ADDR_W  refresh address.
- wr_req  in  1  write sub-controller has a burst to issue (level).
- wr_en  out  1  grant to write sub-controller.
- wr_end  in  1  write burst/precharge done (pulse).
- wr_cmd  in  4  write command.
- wr_bank  in  BANK_W  write bank.
- wr_addr  in  ADDR_W  write address.
- rd_req, rd_en, rd_end, rd_cmd, rd_bank, rd_addr: same as the write set, for reads.
- ref_pending  out  1  refresh waiting; wr/rd must terminate at the next burst boundary.
- ref_overrun  out  1  sticky: a refresh period expired while the previous request was unserved.
- sdram_cmd  out  4  registered command to pins.
- sdram_bank  out  BANK_W  registered bank.
- sdram_addr  out  ADDR_W  registered address.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=S_INIT, sdram_cmd=NOP (4'b0111), sdram_bank=0, sdram_addr=0.
  - ref_en/wr_en/rd_en=0, ref_pending=0, ref_overrun=0.
  - refresh timer=0, last_grant=READ (so the first contested grant goes to write).
  - Reset applies mid-burst too; no command completion is guaranteed.
- States: S_INIT, S_ARB, S_AREF, S_WRITE, S_READ.
- S_INIT:
  - Pin mux selects init_*.
  - Moves to S_ARB on the first cycle init_done=1.
  - Refresh timer held at 0 until then.
- Refresh timer (after init_done):
  - Counts 0..REF_CYCLES-1 and wraps to 0.
  - On wrap, sets ref_pending.
  - If ref_pending is already 1 at wrap, also sets ref_overrun (cleared only by rst).
- S_ARB, evaluated each cycle in this priority order:
  1. ref_pending -> S_AREF.
  2. Else wr_req & rd_req -> grant the opposite of last_grant.
  3. Else wr_req -> S_WRITE.
  4. Else rd_req -> S_READ.
  5. Else stay in S_ARB.
  - Pin mux outputs NOP while in S_ARB.
- Grant outputs:
  - ref_en/wr_en/rd_en are registered and high for exactly the cycles spent in the matching state.
  - They assert on the first cycle in the state, i.e. one cycle after the S_ARB decision edge.
  - last_grant updates on entry to S_WRITE or S_READ.
- S_AREF:
  - Entering clears ref_pending, unless a timer wrap coincides on that same edge, in which case ref_pending stays 1.
  - ref_end -> S_ARB; ref_en drops on the same edge.
- S_WRITE / S_READ:
  - wr_end / rd_end -> S_ARB.
  - The arbiter never preempts mid-burst; the sub-controller watches ref_pending and ends its burst itself.
  - An *_end pulse arriving while not in the matching state is ignored.
- Pin path:
  - One-cycle registered mux of init_*/ref_*/wr_*/rd_* selected by the current state.
  - Bank and address are 0 when the selection is NOP (S_ARB) or refresh (ref has no bank input).
  - Latency from sub-controller cmd input to sdram_cmd is 1 clk.
- After S_AREF/S_WRITE/S_READ, at least one S_ARB cycle always follows; back-to-back grants are therefore separated by exactly one NOP cycle.

Decomposition:
- Shared package sdram_pkg: command encodings CMD_NOP=4'b0111, CMD_PRE, CMD_AREF, CMD_MRS, CMD_ACT, CMD_WR, CMD_RD; state encodings S_INIT..S_READ.
- Natural sub-module: sdram_ref_timer (counter, ref_pending set/clear, ref_overrun). Its inputs are clk, rst, init_done and the ref_ack strobe on S_AREF entry.
- FSM and pin mux stay in sdram_arbiter.

Test Plan:
- Reset/init:
  - Stimulus: rst high 5 cycles, init_cmd=4'b0010, init_done low.
  - Required: sdram_cmd=0111 during rst; sdram_cmd=0010 one cycle after rst drops; no grants.
  - Raise init_done -> next cycle state S_ARB, sdram_cmd=0111.
- Refresh period:
  - Stimulus: init_done, no requests, REF_CYCLES=780.
  - Required: ref_pending at cycle 780 after init_done; ref_en the next cycle; ref_en drops on the ref_end edge; next ref_pending 780 cycles after the first.
- Contested grant:
  - Stimulus: wr_req and rd_req both held high.
  - Required: wr_en first; after wr_end, one NOP cycle, then rd_en; after rd_end, wr_en again (strict alternation).
- Refresh during burst:
  - Stimulus: ref_pending rises while in S_WRITE.
  - Required: wr_en stays high until wr_end; then S_AREF is granted before the pending rd_req.
- Overrun:
  - Stimulus: hold wr_en by withholding wr_end for more than 2*780 cycles.
  - Required: ref_overrun=1 at the second wrap and stays 1 until rst.
- Reset mid-op:
  - Stimulus: assert rst during S_READ with rd_cmd=CMD_RD.
  - Required: next edge rd_en=0, sdram_cmd=0111, state S_INIT, ref_overrun=0.
